// File: rtl/i2c_stream_master_if.sv
// Stream and pin bundle between a user process and the I2C bit engine.
// The master modport is the engine's view; the slave modport is the view
// of whatever sits around it (command producer, response consumer, pads).
interface i2c_stream_master_if;
  logic [31:0] input_cmd;
  logic        input_cmd_stb;
  logic        input_cmd_ack;
  logic [31:0] output_rsp;
  logic        output_rsp_stb;
  logic        output_rsp_ack;
  logic        scl_i;
  logic        sda_i;
  logic        scl_oe;
  logic        sda_oe;

  modport master (
    input  input_cmd,
    input  input_cmd_stb,
    output input_cmd_ack,
    output output_rsp,
    output output_rsp_stb,
    input  output_rsp_ack,
    input  scl_i,
    input  sda_i,
    output scl_oe,
    output sda_oe
  );

  modport slave (
    output input_cmd,
    output input_cmd_stb,
    input  input_cmd_ack,
    input  output_rsp,
    input  output_rsp_stb,
    output output_rsp_ack,
    output scl_i,
    output sda_i,
    input  scl_oe,
    input  sda_oe
  );
endinterface

// File: rtl/i2c_stream_master.sv
// Bit-level single-master I2C engine. Takes 32-bit command words
// ([10:8] opcode, [7:0] write data), drives open-drain SCL/SDA through
// pull-low enables, and returns write ACK status or read bytes as 32-bit
// response words. Each bus phase is one quarter of an SCL period; the
// quarter that releases SCL waits for the pin to read high, which gives
// slave clock stretching for free.
module i2c_stream_master #(
  parameter int CLOCK_DIVIDE = 250
) (
  input logic            clk,
  input logic            rst,
  i2c_stream_master_if.master bus
);

  localparam logic [2:0] OP_START     = 3'd0;
  localparam logic [2:0] OP_STOP      = 3'd1;
  localparam logic [2:0] OP_WRITE     = 3'd2;
  localparam logic [2:0] OP_READ_ACK  = 3'd3;
  localparam logic [2:0] OP_READ_NACK = 3'd4;

  localparam logic [15:0] QUARTER_LAST = 16'(CLOCK_DIVIDE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    STOP,
    XFER,
    RESPOND,
    DISCARD
  } state_t;

  state_t      state;
  logic [15:0] qcnt;
  logic [1:0]  phase;
  logic [3:0]  bit_idx;
  logic [2:0]  op;
  logic [7:0]  shift;
  logic        nack;
  logic        scl_oe;
  logic        sda_oe;
  logic        cmd_ack;
  logic        rsp_stb;
  logic [31:0] rsp;

  logic quarter_done;
  logic stretching;
  logic unused_cmd_bits;

  // Phase 1 of every bus sequence is the one that releases SCL; while a
  // slave holds the line low the quarter counter is parked at zero.
  assign quarter_done    = (qcnt == QUARTER_LAST);
  assign stretching      = (phase == 2'd1) && !bus.scl_i;
  assign unused_cmd_bits = ^bus.input_cmd[31:11];

  assign bus.scl_oe         = scl_oe;
  assign bus.sda_oe         = sda_oe;
  assign bus.input_cmd_ack  = cmd_ack;
  assign bus.output_rsp_stb = rsp_stb;
  assign bus.output_rsp     = rsp;

  // Command/bus/response sequencer; on each quarter tick the outputs of
  // the next phase are registered so the pins change on phase boundaries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      qcnt    <= '0;
      phase   <= '0;
      bit_idx <= '0;
      op      <= '0;
      shift   <= '0;
      nack    <= 1'b0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
      cmd_ack <= 1'b0;
      rsp_stb <= 1'b0;
      rsp     <= '0;
    end else begin
      case (state)
        IDLE: begin
          qcnt    <= '0;
          phase   <= '0;
          bit_idx <= '0;
          if (cmd_ack && bus.input_cmd_stb) begin
            cmd_ack <= 1'b0;
            op      <= bus.input_cmd[10:8];
            shift   <= bus.input_cmd[7:0];
            case (bus.input_cmd[10:8])
              OP_START: begin
                state  <= START;
                sda_oe <= 1'b0;
              end
              OP_STOP: begin
                state  <= STOP;
                sda_oe <= 1'b1;
              end
              OP_WRITE: begin
                state  <= XFER;
                scl_oe <= 1'b1;
                sda_oe <= ~bus.input_cmd[7];
              end
              OP_READ_ACK, OP_READ_NACK: begin
                state  <= XFER;
                scl_oe <= 1'b1;
                sda_oe <= 1'b0;
              end
              default: state <= DISCARD;
            endcase
          end else begin
            cmd_ack <= 1'b1;
          end
        end

        START, STOP, XFER: begin
          if (stretching) begin
            qcnt <= '0;
          end else if (!quarter_done) begin
            qcnt <= qcnt + 16'd1;
          end else begin
            qcnt  <= '0;
            phase <= phase + 2'd1;
            if (state == START) begin
              case (phase)
                2'd0: scl_oe <= 1'b0;
                2'd1: sda_oe <= 1'b1;
                2'd2: scl_oe <= 1'b1;
                default: begin
                  state   <= IDLE;
                  cmd_ack <= 1'b1;
                end
              endcase
            end else if (state == STOP) begin
              case (phase)
                2'd0: scl_oe <= 1'b0;
                2'd1: sda_oe <= 1'b0;
                2'd3: begin
                  state   <= IDLE;
                  cmd_ack <= 1'b1;
                end
                default: ;
              endcase
            end else begin
              case (phase)
                2'd0: scl_oe <= 1'b0;
                2'd2: begin
                  scl_oe <= 1'b1;
                  if (bit_idx == 4'd8) begin
                    nack <= bus.sda_i;
                  end else begin
                    shift <= {shift[6:0], bus.sda_i};
                  end
                end
                2'd3: begin
                  if (bit_idx == 4'd8) begin
                    state   <= RESPOND;
                    rsp_stb <= 1'b1;
                    rsp     <= (op == OP_WRITE) ? {31'b0, nack} : {24'b0, shift};
                  end else begin
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == 4'd7) begin
                      sda_oe <= (op == OP_READ_ACK);
                    end else begin
                      sda_oe <= (op == OP_WRITE) & ~shift[7];
                    end
                  end
                end
                default: ;
              endcase
            end
          end
        end

        RESPOND: begin
          if (bus.output_rsp_ack) begin
            rsp_stb <= 1'b0;
            state   <= IDLE;
            cmd_ack <= 1'b1;
          end
        end

        DISCARD: begin
          state   <= IDLE;
          cmd_ack <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_stream_master.sv
// Bench for i2c_stream_master with CLOCK_DIVIDE=4: a bit-level slave
// model, a pin monitor recording SCL edges and START/STOP conditions, and
// a response scoreboard fed by the stimulus thread.
module tb_i2c_stream_master;

  localparam logic [2:0] OP_START     = 3'd0;
  localparam logic [2:0] OP_STOP      = 3'd1;
  localparam logic [2:0] OP_WRITE     = 3'd2;
  localparam logic [2:0] OP_READ_ACK  = 3'd3;
  localparam logic [2:0] OP_READ_NACK = 3'd4;

  logic clk;
  logic rst;
  i2c_stream_master_if bus();

  i2c_stream_master #(.CLOCK_DIVIDE(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // slave model controls
  int         slave_mode = 0;   // 0 none, 1 write target, 2 read source
  logic [7:0] slave_byte = 8'h00;
  logic       slave_ack  = 1'b0;
  int         epoch      = 0;
  int         stretch_bit = 0;
  int         stretch_len = 0;
  // slave model state
  int   seen_epoch  = -1;
  int   cur_bit     = 0;
  int   stretch_cnt = 0;
  logic scl_prev    = 1'b1;
  logic sda_pull;
  logic scl_pull;

  // pin monitor records
  int   cyc = 0;
  int   rise_t[$];
  logic rise_sda[$];
  logic rise_oe[$];
  int   fall_t[$];
  int   start_cnt = 0;
  int   stop_cnt  = 0;
  int   scl_edges = 0;
  int   sda_edges = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.scl_i = ~bus.scl_oe & ~scl_pull;
  assign bus.sda_i = ~bus.sda_oe & ~sda_pull;

  always_comb begin
    sda_pull = 1'b0;
    scl_pull = 1'b0;
    if (seen_epoch == epoch) begin
      if (slave_mode == 1 && cur_bit == 8) sda_pull = slave_ack;
      if (slave_mode == 2 && cur_bit < 8) sda_pull = ~slave_byte[3'(7 - cur_bit)];
      if (stretch_len > 0 && cur_bit == stretch_bit && !bus.scl_oe && stretch_cnt < stretch_len)
        scl_pull = 1'b1;
    end
  end

  always @(posedge clk) begin
    scl_prev <= bus.scl_i;
    if (seen_epoch != epoch) begin
      seen_epoch  <= epoch;
      cur_bit     <= 0;
      stretch_cnt <= 0;
    end else begin
      if (scl_prev && !bus.scl_i) cur_bit <= cur_bit + 1;
      if (scl_pull) stretch_cnt <= stretch_cnt + 1;
    end
  end

  initial begin : pin_mon
    logic scl_p;
    logic sda_p;
    scl_p = 1'b1;
    sda_p = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.scl_i && !scl_p) begin
        rise_t.push_back(cyc);
        rise_sda.push_back(bus.sda_i);
        rise_oe.push_back(bus.sda_oe);
      end
      if (!bus.scl_i && scl_p) fall_t.push_back(cyc);
      if (bus.scl_i && scl_p && sda_p && !bus.sda_i) start_cnt++;
      if (bus.scl_i && scl_p && !sda_p && bus.sda_i) stop_cnt++;
      if (bus.scl_i != scl_p) scl_edges++;
      if (bus.sda_i != sda_p) sda_edges++;
      scl_p = bus.scl_i;
      sda_p = bus.sda_i;
    end
  end

  initial begin : rsp_mon
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (bus.output_rsp_stb && bus.output_rsp_ack) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rsp_unexpected got=%h required=none", bus.output_rsp);
        end else begin
          e = exp_q.pop_front();
          if (bus.output_rsp !== e) begin
            n_err++;
            $display("FAIL rsp got=%h required=%h", bus.output_rsp, e);
          end else begin
            $display("rsp got=%h expected=%h ok", bus.output_rsp, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end else begin
      $display("check %s got=%h ok", name, got);
    end
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] data);
    int i;
    @(negedge clk);
    bus.input_cmd     = {21'b0, op, data};
    bus.input_cmd_stb = 1'b1;
    for (i = 0; i < 5000; i++) begin
      if (bus.input_cmd_ack) break;
      @(negedge clk);
    end
    if (!bus.input_cmd_ack) begin
      check("cmd_accept_timeout", 32'd0, 32'd1);
      bus.input_cmd_stb = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.input_cmd_stb = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus.input_cmd_ack) break;
    end
    if (!bus.input_cmd_ack) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic byte_op(input logic [2:0] op, input logic [7:0] data,
                         input logic [7:0] sbyte, input logic sack, input logic [31:0] expected);
    slave_mode = (op == OP_WRITE) ? 1 : 2;
    slave_byte = sbyte;
    slave_ack  = sack;
    epoch++;
    exp_q.push_back(expected);
    send_cmd(op, data);
    wait_idle();
  endtask

  function automatic int rise_at(input int i);
    return (i < rise_t.size()) ? rise_t[i] : -1000;
  endfunction

  function automatic int fall_at(input int i);
    return (i < fall_t.size()) ? fall_t[i] : -1000;
  endfunction

  function automatic logic [8:0] bits_from(input int m);
    logic [8:0] v;
    v = '0;
    for (int k = 0; k < 9; k++)
      v = {v[7:0], ((m + k) < rise_sda.size()) ? rise_sda[m + k] : 1'bx};
    return v;
  endfunction

  function automatic int timing_errs(input int mr, input int mf);
    int errs;
    errs = 0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0 && rise_at(mr + k) - rise_at(mr + k - 1) != 16) errs++;
      if (fall_at(mf + k) - rise_at(mr + k) != 8) errs++;
    end
    return errs;
  endfunction

  initial begin : stim
    int mr;
    int mf;
    int s0;
    int p0;
    int e0;
    logic held_ok;

    bus.input_cmd      = '0;
    bus.input_cmd_stb  = 1'b0;
    bus.output_rsp_ack = 1'b1;
    rst = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_scl_oe", {31'b0, bus.scl_oe}, 32'd0);
    check("rst_sda_oe", {31'b0, bus.sda_oe}, 32'd0);
    check("rst_cmd_ack", {31'b0, bus.input_cmd_ack}, 32'd0);
    check("rst_rsp_stb", {31'b0, bus.output_rsp_stb}, 32'd0);
    check("rst_rsp", bus.output_rsp, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ack_after_reset", {31'b0, bus.input_cmd_ack}, 32'd1);

    // START + WRITE 0x90, slave ACKs
    s0 = start_cnt;
    send_cmd(OP_START, 8'h00);
    wait_idle();
    check("start_from_idle", start_cnt - s0, 32'd1);
    mr = rise_t.size();
    mf = fall_t.size();
    byte_op(OP_WRITE, 8'h90, 8'h00, 1'b1, 32'h0000_0000);
    check("wr_ack_pulses", rise_t.size() - mr, 32'd9);
    check("wr_ack_bits", {23'b0, bits_from(mr)}, {23'b0, 9'b1_0010_0000});
    check("wr_ack_timing_errs", timing_errs(mr, mf), 32'd0);

    // repeated START + WRITE 0x90, slave NACKs
    send_cmd(OP_START, 8'h00);
    wait_idle();
    mr = rise_t.size();
    byte_op(OP_WRITE, 8'h90, 8'h00, 1'b0, 32'h0000_0001);
    check("wr_nack_bits", {23'b0, bits_from(mr)}, {23'b0, 9'b1_0010_0001});

    // READ_ACK of 0xA5: master must pull SDA on the 9th high
    mr = rise_t.size();
    byte_op(OP_READ_ACK, 8'h00, 8'hA5, 1'b0, 32'h0000_00A5);
    check("rd_ack_9th_oe", {31'b0, ((mr + 8) < rise_oe.size()) ? rise_oe[mr + 8] : 1'bx}, 32'd1);
    check("rd_ack_bits", {23'b0, bits_from(mr)}, {23'b0, 8'hA5, 1'b0});

    // START, WRITE, START, READ_NACK 0x3C, STOP
    s0 = start_cnt;
    p0 = stop_cnt;
    send_cmd(OP_START, 8'h00);
    wait_idle();
    byte_op(OP_WRITE, 8'hA0, 8'h00, 1'b1, 32'h0000_0000);
    send_cmd(OP_START, 8'h00);
    wait_idle();
    mr = rise_t.size();
    byte_op(OP_READ_NACK, 8'h00, 8'h3C, 1'b0, 32'h0000_003C);
    check("rd_nack_9th_oe_sda",
          {30'b0, ((mr + 8) < rise_oe.size()) ? {rise_oe[mr + 8], rise_sda[mr + 8]} : 2'bxx},
          32'd1);
    send_cmd(OP_STOP, 8'h00);
    wait_idle();
    check("seq_start_conditions", start_cnt - s0, 32'd2);
    check("seq_stop_conditions", stop_cnt - p0, 32'd1);
    check("seq_lines_released", {28'b0, bus.scl_i, bus.sda_i, bus.scl_oe, bus.sda_oe}, 32'b1100);

    // clock stretching: slave holds SCL 20 cycles on bit 3
    send_cmd(OP_START, 8'h00);
    wait_idle();
    stretch_bit = 3;
    stretch_len = 20;
    mr = rise_t.size();
    mf = fall_t.size();
    byte_op(OP_WRITE, 8'h55, 8'h00, 1'b1, 32'h0000_0000);
    stretch_len = 0;
    check("stretch_gap_2_3", rise_at(mr + 3) - rise_at(mr + 2), 32'd36);
    check("stretch_gap_3_4", rise_at(mr + 4) - rise_at(mr + 3), 32'd16);
    check("stretch_high_3", fall_at(mf + 3) - rise_at(mr + 3), 32'd8);

    // response back-pressure: hold output_rsp_ack low 50 cycles
    bus.output_rsp_ack = 1'b0;
    slave_mode = 2;
    slave_byte = 8'h81;
    epoch++;
    exp_q.push_back(32'h0000_0081);
    send_cmd(OP_READ_ACK, 8'h00);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.output_rsp_stb) break;
    end
    check("bp_rsp_stb_rises", {31'b0, bus.output_rsp_stb}, 32'd1);
    held_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(bus.output_rsp_stb === 1'b1 && bus.output_rsp === 32'h81 && bus.input_cmd_ack === 1'b0))
        held_ok = 1'b0;
    end
    check("bp_held_50", {31'b0, held_ok}, 32'd1);
    @(posedge clk);
    #1;
    bus.output_rsp_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_stb_drops", {31'b0, bus.output_rsp_stb}, 32'd0);
    check("bp_cmd_ack_back", {31'b0, bus.input_cmd_ack}, 32'd1);
    send_cmd(OP_STOP, 8'h00);
    wait_idle();

    // opcode 6: consumed silently
    slave_mode = 0;
    s0 = scl_edges;
    e0 = sda_edges;
    send_cmd(3'd6, 8'hFF);
    wait_idle();
    repeat (20) @(negedge clk);
    check("op6_pin_edges", (scl_edges - s0) + (sda_edges - e0), 32'd0);
    check("op6_oe", {30'b0, bus.scl_oe, bus.sda_oe}, 32'd0);
    check("op6_no_rsp_ack", {30'b0, bus.output_rsp_stb, bus.input_cmd_ack}, 32'd1);

    // reset in the middle of a byte
    send_cmd(OP_WRITE, 8'h00);
    repeat (30) @(negedge clk);
    check("mid_byte_driving", {30'b0, bus.scl_oe, bus.sda_oe}, 32'b11);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_released", {29'b0, bus.scl_oe, bus.sda_oe, bus.input_cmd_ack}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ack_back", {31'b0, bus.input_cmd_ack}, 32'd1);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_stream_master.md
Name: i2c_stream_master

Overview:
- Bit-level I2C bus engine sitting behind the i2c stream pair of a user design.
- Consumes 32-bit command words from a process's i2c output stream and drives open-drain SCL/SDA.
- Returns write-acknowledge status and read bytes on a 32-bit response stream, which feeds the process's i2c input.
- Single master; supports repeated start and slave clock stretching.

Parameters:
- CLOCK_DIVIDE, 250, clk cycles per SCL quarter-period (100 MHz clk gives 100 kHz SCL); legal range 2 to 65535.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- input_cmd  in  32  command word: [10:8] opcode, [7:0] write data
- input_cmd_stb  in  1  command valid
- input_cmd_ack  out  1  command accepted
- output_rsp  out  32  response word
- output_rsp_stb  out  1  response valid
- output_rsp_ack  in  1  response taken
- scl_i  in  1  sampled SCL pin
- sda_i  in  1  sampled SDA pin
- scl_oe  out  1  1 = pull SCL low; 0 = release
- sda_oe  out  1  1 = pull SDA low; 0 = release

Behaviour:
- Reset values (rst low at a clk edge): scl_oe=0, sda_oe=0, input_cmd_ack=0, output_rsp_stb=0, output_rsp=0, state=IDLE, quarter counter=0.
- Reset mid-transfer aborts the transfer and releases both lines on that edge. No STOP is generated.
- Opcodes:
  - 0 START: also used as repeated start.
  - 1 STOP.
  - 2 WRITE: sends input_cmd[7:0].
  - 3 READ_ACK: reads a byte, master drives ACK.
  - 4 READ_NACK: reads a byte, master releases SDA on the 9th bit.
  - 5 to 7: consumed, no bus activity, no response.
- Command handshake:
  - input_cmd_ack=1 only in IDLE.
  - A transfer occurs when stb and ack are both high at a clk edge.
  - ack drops the next cycle. The command is latched and the FSM leaves IDLE.
- Response handshake:
  - Only WRITE and READ_* produce a response.
  - output_rsp_stb rises in RESPOND with output_rsp stable.
  - Both are held until output_rsp_ack=1 at an edge; stb is low the following cycle and the FSM returns to IDLE.
  - No new command is accepted while a response is pending.
- Response format:
  - WRITE: {31'b0, nack}, where nack = sda_i sampled on the 9th bit.
  - READ: {24'b0, byte}, MSB received first.
- Timing:
  - A quarter tick elapses every CLOCK_DIVIDE cycles.
  - Every phase below lasts one quarter.
  - A phase that releases SCL does not advance until scl_i=1 (stretching), then runs its full quarter.
- START phases:
  1. Release SDA.
  2. Release SCL, wait high.
  3. SDA low.
  4. SCL low.
  - From an idle bus (SCL already high), phases 1–2 complete in one quarter each with no effect.
- STOP phases:
  1. SDA low.
  2. Release SCL, wait high.
  3. Release SDA.
  4. Idle quarter.
  - Bus is left with both lines released.
- Data bit phases (x8, MSB first, then 9th ACK bit):
  1. SCL low, set SDA (sda_oe = ~bit; released for reads).
  2. Release SCL, wait high.
  3. Sample sda_i at the end of this quarter.
  4. SCL low.
- 9th bit:
  - WRITE releases SDA and samples nack.
  - READ_ACK drives sda_oe=1.
  - READ_NACK releases SDA.
- After any byte, SCL remains low and SDA is held at its last value until the next command.
- Minimum byte time is 36*CLOCK_DIVIDE cycles plus stretch time.
- WRITE/READ issued without a preceding START is executed as-is; no protocol checking.
- Arbitration loss is not detected (single-master bus).

Test Plan:
- CLOCK_DIVIDE=4:
  - START, WRITE 0x90 with slave model ACKing → SCL shows 9 pulses of 16 cycles each; SDA bits 1,0,0,1,0,0,0,0; output_rsp=0x00000000.
  - Same as above with slave NACKing → output_rsp=0x00000001.
- READ_ACK with slave driving 0xA5 → output_rsp=0x000000A5; sda_oe=1 during the 9th SCL high.
- READ_NACK with slave driving 0x3C → output_rsp=0x0000003C; SDA released on the 9th bit.
- Command sequences:
  - START, WRITE, START, READ_NACK, STOP → repeated start: SDA falls while SCL high; final STOP: SDA rises while SCL high; both lines released at end.
- Flow control:
  - Hold scl_i low 20 cycles in a high phase → bit extends exactly 20 cycles.
  - Hold output_rsp_ack low 50 cycles → stb and data held, input_cmd_ack stays 0.
- Robustness:
  - Opcode 6 → consumed, no SCL/SDA change, no response.
  - rst low mid-byte → scl_oe=sda_oe=0 next edge, input_cmd_ack=1 after release.
